// File: rtl/seq_pkg.sv
// Shared types and constants for the serial test-sequence transmitter.
// The PRBS7 constants are used only when SEQ_GEN_PRBS_EN is defined.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  // The sequence the companion detector recognises.
  localparam logic [8:0] DEF_PATTERN = 9'b1_0101_1011;

  // PRBS7, polynomial x^7 + x^6 + 1, as a Fibonacci LFSR on bits [6:0].
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

endpackage

// File: rtl/seq_prbs7.sv
// Free-running PRBS7 filler generator (x^7 + x^6 + 1, seed 7'h7F).
// Instantiated by seq_gen only when SEQ_GEN_PRBS_EN is defined.
module seq_prbs7
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic prbs_out
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[5:0], lfsr_q[PRBS7_TAP_HI] ^ lfsr_q[PRBS7_TAP_LO]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS7_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign prbs_out = lfsr_q[6];

endmodule

// File: rtl/seq_gen.sv
// Serial test-sequence transmitter: sends a latched pattern MSB-first, repeated
// with an idle gap. Define SEQ_GEN_PRBS_EN to fill idle cycles with PRBS7.
module seq_gen
  import seq_pkg::*;
#(
  parameter int PAT_WIDTH = 9,
  parameter int CNT_WIDTH = 4,
  parameter int GAP_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PAT_WIDTH-1:0] pattern,
  input  logic [CNT_WIDTH-1:0] repeat_num,
  input  logic [GAP_WIDTH-1:0] gap_len,
  output logic                 seq_out,
  output logic                 seq_valid,
  output logic                 bit_last,
  output logic                 busy,
  output logic                 done
);

  localparam int              BCW     = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;
  localparam logic [BCW-1:0]  BIT_TOP = BCW'(PAT_WIDTH - 1);

  seq_state_t           state_q,     state_d;
  logic [PAT_WIDTH-1:0] pat_q,       pat_d;
  logic [BCW-1:0]       bit_cnt_q,   bit_cnt_d;
  logic [CNT_WIDTH-1:0] rep_cnt_q,   rep_cnt_d;
  logic [GAP_WIDTH-1:0] gap_len_q,   gap_len_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q,   gap_cnt_d;
  logic                 seq_out_q,   seq_out_d;
  logic                 seq_valid_q, seq_valid_d;
  logic                 bit_last_q,  bit_last_d;
  logic                 done_q,      done_d;
  logic                 filler;
  logic                 go_idle;

`ifdef SEQ_GEN_PRBS_EN
  seq_prbs7 u_prbs (
    .clk      (clk),
    .rst_n    (rst_n),
    .prbs_out (filler)
  );
`else
  assign filler = 1'b0;
`endif

  // Output flops are loaded with what the next state presents, so the first
  // bit is visible right after the edge that accepts start.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    bit_cnt_d   = bit_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    gap_len_d   = gap_len_q;
    gap_cnt_d   = gap_cnt_q;
    seq_out_d   = 1'b0;
    seq_valid_d = 1'b0;
    bit_last_d  = 1'b0;
    done_d      = 1'b0;
    go_idle     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SEND;
          pat_d       = pattern;
          rep_cnt_d   = repeat_num;
          gap_len_d   = gap_len;
          gap_cnt_d   = '0;
          bit_cnt_d   = BIT_TOP;
          seq_valid_d = 1'b1;
          seq_out_d   = pattern[PAT_WIDTH-1];
        end
      end

      ST_SEND: begin
        if (bit_cnt_q != '0) begin
          bit_cnt_d   = bit_cnt_q - BCW'(1);
          seq_valid_d = 1'b1;
          seq_out_d   = pat_q[bit_cnt_q - BCW'(1)];
          bit_last_d  = (bit_cnt_q == BCW'(1));
        end else if (rep_cnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (gap_len_q == '0) begin
          bit_cnt_d   = BIT_TOP;
          rep_cnt_d   = rep_cnt_q - CNT_WIDTH'(1);
          seq_valid_d = 1'b1;
          seq_out_d   = pat_q[PAT_WIDTH-1];
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = gap_len_q - GAP_WIDTH'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d     = ST_SEND;
          bit_cnt_d   = BIT_TOP;
          rep_cnt_d   = rep_cnt_q - CNT_WIDTH'(1);
          seq_valid_d = 1'b1;
          seq_out_d   = pat_q[PAT_WIDTH-1];
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      ST_DONE: begin
        go_idle = 1'b1;
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    // abort only has meaning once a transfer is running
    if (abort && (state_q != ST_IDLE)) begin
      go_idle = 1'b1;
    end

    if (go_idle) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      rep_cnt_d   = '0;
      gap_cnt_d   = '0;
      seq_valid_d = 1'b0;
      seq_out_d   = 1'b0;
      bit_last_d  = 1'b0;
      done_d      = 1'b0;
    end

    if (!seq_valid_d) begin
      seq_out_d = filler;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      bit_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      seq_out_q   <= 1'b0;
      seq_valid_q <= 1'b0;
      bit_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      gap_len_q   <= gap_len_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
      bit_last_q  <= bit_last_d;
      done_q      <= done_d;
    end
  end

  assign seq_out   = seq_out_q;
  assign seq_valid = seq_valid_q;
  assign bit_last  = bit_last_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_SEND) || (state_q == ST_GAP) || (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: expected per-cycle output vectors
// {busy, seq_valid, seq_out, bit_last, done} are built from the transfer parameters.
module tb_seq_gen;
  import seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [8:0] pattern;
  logic [3:0] repeat_num;
  logic [3:0] gap_len;
  logic       seq_out;
  logic       seq_valid;
  logic       bit_last;
  logic       busy;
  logic       done;

  logic [4:0] obs;
  logic [4:0] exp_q[$];
  int         n_tests;
  int         n_fail;

  seq_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .repeat_num (repeat_num),
    .gap_len    (gap_len),
    .seq_out    (seq_out),
    .seq_valid  (seq_valid),
    .bit_last   (bit_last),
    .busy       (busy),
    .done       (done)
  );

  assign obs = {busy, seq_valid, seq_out, bit_last, done};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // seq_out is don't-care on idle cycles when the filler is enabled
  function automatic logic [4:0] msk(input logic [4:0] v, input logic [4:0] e);
    logic [4:0] r;
    r = v;
`ifdef SEQ_GEN_PRBS_EN
    if (!e[3]) r[2] = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
    n_tests++;
    assert (msk(o, e) === msk(e, e)) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic build_exp(input logic [8:0] pat, input int r, input int g);
    exp_q.delete();
    for (int rep = 0; rep <= r; rep++) begin
      for (int i = 8; i >= 0; i--) begin
        exp_q.push_back({1'b1, 1'b1, pat[i], (i == 0), 1'b0});
      end
      if (rep < r) begin
        for (int k = 0; k < g; k++) exp_q.push_back(5'b10000);
      end
    end
    exp_q.push_back(5'b10001);
    exp_q.push_back(5'b00000);
  endtask

  // driver: called at a negedge with busy low; returns at the negedge after acceptance
  task automatic start_xfer(input logic [8:0] pat, input logic [3:0] r, input logic [3:0] g,
                            input logic abort_v);
    start      = 1'b1;
    abort      = abort_v;
    pattern    = pat;
    repeat_num = r;
    gap_len    = g;
    @(negedge clk);
    start      = 1'b0;
    abort      = 1'b0;
    pattern    = 9'($urandom_range(0, 511));
    repeat_num = 4'($urandom_range(0, 15));
    gap_len    = 4'($urandom_range(0, 15));
  endtask

  // scoreboard: compare n queued cycles; optional start pulse with junk pattern at cycle mid
  task automatic drain(input string tag, input int n, input int mid);
    logic [4:0] e;
    for (int cyc = 0; cyc < n; cyc++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d", tag, cyc), obs, e);
      if (cyc == mid) begin
        start   = 1'b1;
        pattern = 9'b0_1111_0000;
      end else begin
        start = 1'b0;
      end
      if (cyc < n - 1) @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    pattern    = '0;
    repeat_num = '0;
    gap_len    = '0;

    // reset state
    @(negedge clk);
    check("reset_hold", obs, 5'b00000);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", obs, 5'b00000);

    // single pattern: 9 bits, done in cycle 10
    build_exp(DEF_PATTERN, 0, 0);
    start_xfer(DEF_PATTERN, 4'd0, 4'd0, 1'b0);
    drain("single", exp_q.size(), -1);

    // repeats with gap: done in cycle 34
    build_exp(DEF_PATTERN, 2, 3);
    start_xfer(DEF_PATTERN, 4'd2, 4'd3, 1'b0);
    drain("rep_gap", exp_q.size(), -1);

    // back-to-back: 18 contiguous bits, done in cycle 19
    build_exp(9'b0_1100_1110, 1, 0);
    start_xfer(9'b0_1100_1110, 4'd1, 4'd0, 1'b0);
    drain("b2b", exp_q.size(), -1);

    // gap of one cycle, a different pattern
    build_exp(9'b1_1000_0011, 1, 1);
    start_xfer(9'b1_1000_0011, 4'd1, 4'd1, 1'b0);
    drain("gap1", exp_q.size(), -1);

    // start while busy is ignored
    build_exp(DEF_PATTERN, 1, 2);
    start_xfer(DEF_PATTERN, 4'd1, 4'd2, 1'b0);
    drain("busy_start", exp_q.size(), 3);

    // abort on the 4th bit: idle next cycle and no done afterwards
    build_exp(DEF_PATTERN, 1, 2);
    start_xfer(DEF_PATTERN, 4'd1, 4'd2, 1'b0);
    drain("abort_pre", 4, -1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", obs, 5'b00000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_nodone%0d", k), obs, 5'b00000);
    end

    // start together with abort in IDLE is accepted
    build_exp(9'b0_0110_1101, 0, 5);
    start_xfer(9'b0_0110_1101, 4'd0, 4'd5, 1'b1);
    drain("start_abort", exp_q.size(), -1);

    // asynchronous reset during GAP
    build_exp(DEF_PATTERN, 1, 3);
    start_xfer(DEF_PATTERN, 4'd1, 4'd3, 1'b0);
    drain("rst_pre", 10, -1);
    #1 rst_n = 1'b0;
    #1 check("rst_async", obs, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle", obs, 5'b00000);

    // normal transfer after reset
    build_exp(DEF_PATTERN, 0, 0);
    start_xfer(DEF_PATTERN, 4'd0, 4'd0, 1'b0);
    drain("post_rst", exp_q.size(), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
